load_processing_unit: RTL and testbench
=======================================

# load_processing_unit

Load processing unit for the RV32IM pipelined core, placed in the memory-access/writeback path after the data memory read port. It takes the raw 32-bit word read from data memory and produces the architecturally correct load result for LB, LH, LW, LBU and LHU. It does this by selecting the addressed byte or halfword lane and sign- or zero-extending it. The result is registered once and handed to the writeback stage with a valid flag.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 3-bit FUNC3, 2-bit byte offset.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- VALID_IN  input  1  load result request this cycle.
- FUNC3  input  3  RISC-V load funct3.
- ADDR_OFFSET  input  2  byte offset, i.e. effective address bits [1:0].
- DATA_OUT  input  32  raw word from data memory, little-endian lanes.
- PROCESSED_DATA_OUT  output  32  extended load result (registered).
- VALID_OUT  output  1  PROCESSED_DATA_OUT is valid this cycle.
- ILLEGAL_FUNC3  output  1  registered flag; FUNC3 is not a load encoding.
- MISALIGNED  output  1  registered flag; access not naturally aligned (see Configuration).

## Operation
- Byte lane: b = DATA_OUT[8*ADDR_OFFSET +: 8].
- Halfword lane: h = ADDR_OFFSET[1] ? DATA_OUT[31:16] : DATA_OUT[15:0]. ADDR_OFFSET[0] is ignored for lane selection.
- Word: DATA_OUT unchanged, regardless of ADDR_OFFSET.
- FUNC3 decoding:
  - 000 LB: {{24{b[7]}}, b}.
  - 001 LH: {{16{h[15]}}, h}.
  - 010 LW: DATA_OUT.
  - 100 LBU: {24'b0, b}.
  - 101 LHU: {16'b0, h}.
  - 011/110/111: result 32'h0 and ILLEGAL_FUNC3=1.
- Result, flags and VALID_OUT are captured only when VALID_IN=1.
- When VALID_IN=0:
  - VALID_OUT drops to 0 next cycle.
  - PROCESSED_DATA_OUT holds its last value.
  - ILLEGAL_FUNC3 and MISALIGNED clear to 0.
- ILLEGAL_FUNC3 and MISALIGNED are meaningful only while VALID_OUT=1.

## Timing
- Latency: exactly 1 cycle. Inputs sampled on rising CLK with VALID_IN=1 appear on outputs after that edge.
- Throughput: one load per cycle; back-to-back VALID_IN is supported with no bubbles.
- No backpressure; the consumer always accepts.
- Reset (RESET_N low, asynchronous): PROCESSED_DATA_OUT=32'h0, VALID_OUT=0, ILLEGAL_FUNC3=0, MISALIGNED=0.
- Reset asserted mid-stream discards any in-flight result. The first valid output after reset release follows the first VALID_IN edge.
- No state machine beyond the output register stage.

## Configuration
- Macro LPU_MISALIGN_CHECK_EN.
- When defined:
  - MISALIGNED=1 for LH/LHU with ADDR_OFFSET[0]=1, and for LW with ADDR_OFFSET≠0.
  - A misaligned access forces PROCESSED_DATA_OUT to 32'h0; VALID_OUT still asserts.
- When undefined: MISALIGNED is tied 0, and lane selection proceeds as in Operation with no forcing.

## Structure
- Shared package lpu_pkg holds:
  - localparams for the funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - the 32-bit data width constant.
- One combinational sub-module, load_extract, holds the lane select, extension, illegal detect and misalign detect logic.
- The top level is the valid-qualified output register around load_extract.

## Test plan
- Reset: assert RESET_N=0 mid-operation -> all outputs 0 immediately (asynchronous), VALID_OUT=0.
- All-ones data, offset 0, VALID_IN=1, DATA_OUT=32'hFFFFFFFF, one cycle per FUNC3 value -> next cycle:
  - LB 32'hFFFFFFFF;
  - LH 32'hFFFFFFFF;
  - LW 32'hFFFFFFFF;
  - LBU 32'h000000FF;
  - LHU 32'h0000FFFF.
- Lane selection with DATA_OUT=32'h12345678:
  - LB off 0 -> 32'h00000078;
  - LBU off 3 -> 32'h00000012;
  - LHU off 2 -> 32'h00001234;
  - LB with DATA_OUT=32'h00008000, off 1 -> 32'hFFFFFF80.
- Illegal: FUNC3=3'b011, DATA_OUT=32'hDEADBEEF -> PROCESSED_DATA_OUT=0, ILLEGAL_FUNC3=1, VALID_OUT=1.
- Misalign: LW off 1 -> with LPU_MISALIGN_CHECK_EN, MISALIGNED=1 and data 0; without it, MISALIGNED=0 and data equals DATA_OUT.
- Gating: VALID_IN=0 after a valid LW -> VALID_OUT=0 next cycle, data held, flags 0; back-to-back loads each produce output after 1 cycle.

Source files
------------

// File: rtl/lpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lpu_pkg
// Description : Shared constants for the load processing unit. Holds the
//               data width and the RISC-V load funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package lpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage : lpu_pkg
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational load lane select and sign/zero extension for
//               LB/LH/LW/LBU/LHU, plus illegal-funct3 and misalignment
//               detection.
// Ports       : func3_i        - RISC-V load funct3
//               addr_offset_i  - effective address bits [1:0]
//               data_i         - raw little-endian word from data memory
//               result_o       - extended load result
//               illegal_o      - funct3 is not a load encoding
//               misaligned_o   - access not naturally aligned
// Macro       : LPU_MISALIGN_CHECK_EN - when defined, misaligned LH/LHU/LW
//               raise misaligned_o and force result_o to zero; otherwise
//               misaligned_o is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
  import lpu_pkg::*;
(
  input  logic [2:0]        func3_i,
  input  logic [1:0]        addr_offset_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] result_o,
  output logic              illegal_o,
  output logic              misaligned_o
);

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;
  logic              w_misaligned;

  // Byte lane selected by the full offset.
  always_comb begin
    w_byte = data_i[7:0];
    case (addr_offset_i)
      2'd0: w_byte = data_i[7:0];
      2'd1: w_byte = data_i[15:8];
      2'd2: w_byte = data_i[23:16];
      2'd3: w_byte = data_i[31:24];
      default: w_byte = data_i[7:0];
    endcase
  end

  // Halfword lane uses only offset bit 1; bit 0 does not move the lane.
  assign w_half = addr_offset_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    w_ext     = '0;
    illegal_o = 1'b0;
    case (func3_i)
      F3_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      F3_LH:   w_ext = {{16{w_half[15]}}, w_half};
      F3_LW:   w_ext = data_i;
      F3_LBU:  w_ext = {24'b0, w_byte};
      F3_LHU:  w_ext = {16'b0, w_half};
      default: begin
        w_ext     = '0;
        illegal_o = 1'b1;
      end
    endcase
  end

`ifdef LPU_MISALIGN_CHECK_EN
  always_comb begin
    w_misaligned = 1'b0;
    if ((func3_i == F3_LH) || (func3_i == F3_LHU))
      w_misaligned = addr_offset_i[0];
    else if (func3_i == F3_LW)
      w_misaligned = (addr_offset_i != 2'b00);
  end
  assign result_o = w_misaligned ? '0 : w_ext;
`else
  assign w_misaligned = 1'b0;
  assign result_o     = w_ext;
`endif

  assign misaligned_o = w_misaligned;

endmodule : load_extract
`default_nettype wire

// File: rtl/load_processing_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_processing_unit
// Description : Valid-qualified output register around load_extract. Turns
//               the raw data-memory word into the architectural load result
//               one cycle after VALID_IN.
// Ports       : CLK, RESET_N (async active-low)
//               VALID_IN, FUNC3, ADDR_OFFSET, DATA_OUT    - load request
//               PROCESSED_DATA_OUT, VALID_OUT             - registered result
//               ILLEGAL_FUNC3, MISALIGNED                 - registered flags
// Macro       : LPU_MISALIGN_CHECK_EN - enables misalignment detection and
//               zero-forcing of misaligned results inside load_extract.
// Revision    : 1.0 - initial release
// ============================================================================
module load_processing_unit
  import lpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              VALID_IN,
  input  logic [2:0]        FUNC3,
  input  logic [1:0]        ADDR_OFFSET,
  input  logic [DATA_W-1:0] DATA_OUT,
  output logic [DATA_W-1:0] PROCESSED_DATA_OUT,
  output logic              VALID_OUT,
  output logic              ILLEGAL_FUNC3,
  output logic              MISALIGNED
);

  logic [DATA_W-1:0] w_result;
  logic              w_illegal;
  logic              w_misaligned;

  logic [DATA_W-1:0] data_d,       data_q;
  logic              valid_d,      valid_q;
  logic              illegal_d,    illegal_q;
  logic              misaligned_d, misaligned_q;

  load_extract u_load_extract (
    .func3_i       (FUNC3),
    .addr_offset_i (ADDR_OFFSET),
    .data_i        (DATA_OUT),
    .result_o      (w_result),
    .illegal_o     (w_illegal),
    .misaligned_o  (w_misaligned)
  );

  // Data holds when idle; flags clear so stale errors never linger.
  always_comb begin
    data_d       = data_q;
    valid_d      = VALID_IN;
    illegal_d    = 1'b0;
    misaligned_d = 1'b0;
    if (VALID_IN) begin
      data_d       = w_result;
      illegal_d    = w_illegal;
      misaligned_d = w_misaligned;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      illegal_q    <= illegal_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign PROCESSED_DATA_OUT = data_q;
  assign VALID_OUT          = valid_q;
  assign ILLEGAL_FUNC3      = illegal_q;
  assign MISALIGNED         = misaligned_q;

endmodule : load_processing_unit
`default_nettype wire

// File: tb/tb_load_processing_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_processing_unit
// Description : Directed self-checking bench for load_processing_unit.
//               Honors LPU_MISALIGN_CHECK_EN for the misalignment scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_processing_unit;

  logic        CLK;
  logic        RESET_N;
  logic        VALID_IN;
  logic [2:0]  FUNC3;
  logic [1:0]  ADDR_OFFSET;
  logic [31:0] DATA_OUT;
  logic [31:0] PROCESSED_DATA_OUT;
  logic        VALID_OUT;
  logic        ILLEGAL_FUNC3;
  logic        MISALIGNED;

  int errors = 0;
  int checks = 0;

  load_processing_unit dut (
    .CLK                (CLK),
    .RESET_N            (RESET_N),
    .VALID_IN           (VALID_IN),
    .FUNC3              (FUNC3),
    .ADDR_OFFSET        (ADDR_OFFSET),
    .DATA_OUT           (DATA_OUT),
    .PROCESSED_DATA_OUT (PROCESSED_DATA_OUT),
    .VALID_OUT          (VALID_OUT),
    .ILLEGAL_FUNC3      (ILLEGAL_FUNC3),
    .MISALIGNED         (MISALIGNED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply a request on the falling edge, then wait until just after the
  // capturing rising edge so outputs are stable for sampling.
  task automatic drive(input logic v, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] d);
    @(negedge CLK);
    VALID_IN    = v;
    FUNC3       = f3;
    ADDR_OFFSET = off;
    DATA_OUT    = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; VALID_IN = 1'b0; FUNC3 = 3'b000; ADDR_OFFSET = 2'b00; DATA_OUT = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (PROCESSED_DATA_OUT !== 32'h0 || VALID_OUT !== 1'b0 || ILLEGAL_FUNC3 !== 1'b0 || MISALIGNED !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: data=%h valid=%b ill=%b mis=%b, want 0/0/0/0",
               PROCESSED_DATA_OUT, VALID_OUT, ILLEGAL_FUNC3, MISALIGNED);
    end
    @(negedge CLK); RESET_N = 1'b1;
    // Mid-stream reset: load an illegal op, then drop reset between edges.
    drive(1'b1, 3'b111, 2'd0, 32'hA5A5A5A5);
    drive(1'b1, 3'b010, 2'd0, 32'hA5A5A5A5);
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (PROCESSED_DATA_OUT !== 32'h0 || VALID_OUT !== 1'b0 || ILLEGAL_FUNC3 !== 1'b0 || MISALIGNED !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: data=%h valid=%b ill=%b mis=%b, want 0/0/0/0",
               PROCESSED_DATA_OUT, VALID_OUT, ILLEGAL_FUNC3, MISALIGNED);
    end
    @(negedge CLK); VALID_IN = 1'b0; RESET_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (VALID_OUT !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: valid=%b, want 0", VALID_OUT);
    end
    drive(1'b1, 3'b010, 2'd0, 32'h0BADF00D);
    checks++;
    if (VALID_OUT !== 1'b1 || PROCESSED_DATA_OUT !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL reset_first_valid: valid=%b data=%h, want 1 0badf00d",
               VALID_OUT, PROCESSED_DATA_OUT);
    end
  endtask

  task automatic test_all_ones();
    logic [2:0]  f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h000000FF, 32'h0000FFFF};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, f3[i], 2'd0, 32'hFFFFFFFF);
      checks++;
      if (PROCESSED_DATA_OUT !== exp[i] || VALID_OUT !== 1'b1 || ILLEGAL_FUNC3 !== 1'b0) begin
        errors++;
        $display("FAIL all_ones f3=%b: data=%h valid=%b ill=%b, want %h 1 0",
                 f3[i], PROCESSED_DATA_OUT, VALID_OUT, ILLEGAL_FUNC3, exp[i]);
      end
    end
  endtask

  task automatic test_lanes();
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b101, 3'b000, 3'b001, 3'b000};
    logic [1:0]  off [6] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd2, 2'd2};
    logic [31:0] din [6] = '{32'h12345678, 32'h12345678, 32'h12345678,
                             32'h00008000, 32'h9ABC1234, 32'h00560000};
    logic [31:0] exp [6] = '{32'h00000078, 32'h00000012, 32'h00001234,
                             32'hFFFFFF80, 32'hFFFF9ABC, 32'h00000056};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, f3[i], off[i], din[i]);
      checks++;
      if (PROCESSED_DATA_OUT !== exp[i] || VALID_OUT !== 1'b1) begin
        errors++;
        $display("FAIL lane_%0d: data=%h valid=%b, want %h 1",
                 i, PROCESSED_DATA_OUT, VALID_OUT, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] f3 [3] = '{3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, f3[i], 2'd0, 32'hDEADBEEF);
      checks++;
      if (PROCESSED_DATA_OUT !== 32'h0 || ILLEGAL_FUNC3 !== 1'b1 || VALID_OUT !== 1'b1) begin
        errors++;
        $display("FAIL illegal f3=%b: data=%h ill=%b valid=%b, want 0 1 1",
                 f3[i], PROCESSED_DATA_OUT, ILLEGAL_FUNC3, VALID_OUT);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_lw;
    logic        exp_mis;
`ifdef LPU_MISALIGN_CHECK_EN
    exp_lw = 32'h0; exp_mis = 1'b1;
`else
    exp_lw = 32'hCAFEBABE; exp_mis = 1'b0;
`endif
    drive(1'b1, 3'b010, 2'd1, 32'hCAFEBABE);
    checks++;
    if (PROCESSED_DATA_OUT !== exp_lw || MISALIGNED !== exp_mis || VALID_OUT !== 1'b1) begin
      errors++;
      $display("FAIL misalign_lw: data=%h mis=%b valid=%b, want %h %b 1",
               PROCESSED_DATA_OUT, MISALIGNED, VALID_OUT, exp_lw, exp_mis);
    end
    // LHU at offset 3 reads the upper halfword when not checked.
`ifdef LPU_MISALIGN_CHECK_EN
    exp_lw = 32'h0;
`else
    exp_lw = 32'h0000CAFE;
`endif
    drive(1'b1, 3'b101, 2'd3, 32'hCAFEBABE);
    checks++;
    if (PROCESSED_DATA_OUT !== exp_lw || MISALIGNED !== exp_mis) begin
      errors++;
      $display("FAIL misalign_lhu: data=%h mis=%b, want %h %b",
               PROCESSED_DATA_OUT, MISALIGNED, exp_lw, exp_mis);
    end
    // Byte loads are never misaligned.
    drive(1'b1, 3'b100, 2'd3, 32'hCAFEBABE);
    checks++;
    if (PROCESSED_DATA_OUT !== 32'h000000CA || MISALIGNED !== 1'b0) begin
      errors++;
      $display("FAIL misalign_lbu: data=%h mis=%b, want 000000ca 0",
               PROCESSED_DATA_OUT, MISALIGNED);
    end
  endtask

  task automatic test_gating();
    drive(1'b1, 3'b010, 2'd0, 32'h13579BDF);
    drive(1'b0, 3'b000, 2'd1, 32'hFFFFFFFF);
    checks++;
    if (VALID_OUT !== 1'b0 || PROCESSED_DATA_OUT !== 32'h13579BDF || ILLEGAL_FUNC3 !== 1'b0 || MISALIGNED !== 1'b0) begin
      errors++;
      $display("FAIL gating_hold: valid=%b data=%h ill=%b mis=%b, want 0 13579bdf 0 0",
               VALID_OUT, PROCESSED_DATA_OUT, ILLEGAL_FUNC3, MISALIGNED);
    end
    drive(1'b1, 3'b110, 2'd0, 32'h11111111);
    drive(1'b0, 3'b110, 2'd0, 32'h22222222);
    checks++;
    if (ILLEGAL_FUNC3 !== 1'b0 || VALID_OUT !== 1'b0 || PROCESSED_DATA_OUT !== 32'h0) begin
      errors++;
      $display("FAIL gating_flag_clear: ill=%b valid=%b data=%h, want 0 0 0",
               ILLEGAL_FUNC3, VALID_OUT, PROCESSED_DATA_OUT);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3  [4] = '{3'b000, 3'b001, 3'b100, 3'b010};
    logic [1:0]  off [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
    logic [31:0] din [4] = '{32'h00F00000, 32'h00018001, 32'h0000AB00, 32'h76543210};
    logic [31:0] exp [4] = '{32'hFFFFFFF0, 32'hFFFF8001, 32'h000000AB, 32'h76543210};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, f3[i], off[i], din[i]);
      checks++;
      if (PROCESSED_DATA_OUT !== exp[i] || VALID_OUT !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: data=%h valid=%b, want %h 1",
                 i, PROCESSED_DATA_OUT, VALID_OUT, exp[i]);
      end
    end
    drive(1'b0, 3'b000, 2'd0, 32'h0);
    checks++;
    if (VALID_OUT !== 1'b0 || PROCESSED_DATA_OUT !== 32'h76543210) begin
      errors++;
      $display("FAIL b2b_end: valid=%b data=%h, want 0 76543210",
               VALID_OUT, PROCESSED_DATA_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_lanes();
    test_illegal();
    test_misalign();
    test_gating();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_load_processing_unit
`default_nettype wire
